// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, instruction field positions
// and the two-word instruction test used by the fetch unit and sequencer.
package cpu_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_ADD  = 4'b0000;
    localparam opcode_t OP_SUB  = 4'b0001;
    localparam opcode_t OP_AND  = 4'b0010;
    localparam opcode_t OP_OR   = 4'b0011;
    localparam opcode_t OP_XOR  = 4'b0100;
    localparam opcode_t OP_NAND = 4'b0101;
    localparam opcode_t OP_NOR  = 4'b0110;
    localparam opcode_t OP_XNOR = 4'b0111;
    localparam opcode_t OP_MOV  = 4'b1011;
    localparam opcode_t OP_MVI  = 4'b1100;
    localparam opcode_t OP_LDA  = 4'b1101;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int OP1_HI = 11;
    localparam int OP1_LO = 9;
    localparam int OP2_HI = 8;
    localparam int OP2_LO = 6;

    typedef enum logic {
        FS_IDLE,
        FS_FETCH
    } fetch_state_t;

    // MVI and LDA carry a second word (immediate / address) after the opcode word.
    function automatic logic is_two_word(input opcode_t op);
        return (op == OP_MVI) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/ins_field_split.sv
// Combinational decode of the instruction register into its fields.
module ins_field_split
    import cpu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] ir,
    output logic [3:0]    opcode,
    output logic [2:0]    op1_addr,
    output logic [2:0]    op2_addr,
    output logic          two_word
);

    // Low bits are not decoded here; the reduction keeps them visibly consumed.
    logic unused_low;

    assign opcode     = ir[OPC_HI:OPC_LO];
    assign op1_addr   = ir[OP1_HI:OP1_LO];
    assign op2_addr   = ir[OP2_HI:OP2_LO];
    assign two_word   = is_two_word(ir[OPC_HI:OPC_LO]);
    assign unused_low = ^ir[OP2_LO-1:0];

endmodule

// File: rtl/ins_fetch_unit.sv
// Instruction fetch unit: owns PC/IR/imm, fetches ROM words over req/ack
// with a timeout, and presents decoded fields to the control sequencer.
module ins_fetch_unit
    import cpu_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs_pc_load,
    input  logic          cs_ins_load,
    input  logic          cs_pc_inc,
    input  logic          pc_wr_en,
    input  logic [AW-1:0] pc_wr_data,
    output logic          rom_req,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_rdata,
    input  logic          rom_ack,
    output logic [3:0]    opcode,
    output logic [2:0]    op1_addr,
    output logic [2:0]    op2_addr,
    output logic [DW-1:0] imm,
    output logic          two_word,
    output logic          fetch_busy,
    output logic          ins_valid,
    output logic          fetch_err,
    output logic [AW-1:0] pc
);

    localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    fetch_state_t  state, state_nx;
    logic [DW-1:0] ir;
    logic          word_sel;
    logic [CW-1:0] tmo_cnt;
    logic          start, ack_take, tmo_hit;

    always_ff @(posedge clk) begin
        if (rst) state <= FS_IDLE;
        else     state <= state_nx;
    end

    // Strobes are only honoured in IDLE; acks only while a request is out.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        ack_take = 1'b0;
        tmo_hit  = 1'b0;
        case (state)
            FS_IDLE: begin
                if (cs_pc_load && cs_ins_load) begin
                    state_nx = FS_FETCH;
                    start    = 1'b1;
                end
            end
            FS_FETCH: begin
                if (rom_ack) begin
                    ack_take = 1'b1;
                    state_nx = FS_IDLE;
                end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                    tmo_hit  = 1'b1;
                    state_nx = FS_IDLE;
                end
            end
            default: state_nx = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_req   <= 1'b0;
            rom_addr  <= '0;
            tmo_cnt   <= '0;
            ins_valid <= 1'b0;
            fetch_err <= 1'b0;
            ir        <= '0;
            imm       <= '0;
            word_sel  <= 1'b0;
            pc        <= AW'(RESET_PC);
        end else begin
            rom_req   <= (state_nx == FS_FETCH);
            ins_valid <= ack_take;
            fetch_err <= tmo_hit;
            tmo_cnt   <= (state == FS_FETCH && state_nx == FS_FETCH) ? tmo_cnt + 1'b1 : '0;
            if (start) rom_addr <= pc;
            if (ack_take) begin
                if (!word_sel) begin
                    ir       <= rom_rdata;
                    word_sel <= is_two_word(rom_rdata[OPC_HI:OPC_LO]);
                end else begin
                    imm      <= rom_rdata;
                    word_sel <= 1'b0;
                end
            end
            // A jump abandons any pending second word, so its clear wins over an ack.
            if (pc_wr_en) begin
                pc       <= pc_wr_data;
                word_sel <= 1'b0;
            end else if (cs_pc_inc) begin
                pc <= pc + AW'(1);
            end
        end
    end

    assign fetch_busy = (state == FS_FETCH);

    ins_field_split #(.DW(DW)) u_split (
        .ir       (ir),
        .opcode   (opcode),
        .op1_addr (op1_addr),
        .op2_addr (op2_addr),
        .two_word (two_word)
    );

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Directed + randomized bench for ins_fetch_unit against a transaction-level model.
module tb_ins_fetch_unit;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs_pc_load = 1'b0, cs_ins_load = 1'b0, cs_pc_inc = 1'b0;
    logic          pc_wr_en = 1'b0;
    logic [AW-1:0] pc_wr_data = '0;
    logic [DW-1:0] rom_rdata = '0;
    logic          rom_ack = 1'b0;
    logic          rom_req, two_word, fetch_busy, ins_valid, fetch_err;
    logic [AW-1:0] rom_addr, pc;
    logic [3:0]    opcode;
    logic [2:0]    op1_addr, op2_addr;
    logic [DW-1:0] imm;

    ins_fetch_unit #(.AW(AW), .DW(DW), .RESET_PC(0), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .cs_pc_load(cs_pc_load), .cs_ins_load(cs_ins_load),
        .cs_pc_inc(cs_pc_inc), .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_rdata(rom_rdata), .rom_ack(rom_ack),
        .opcode(opcode), .op1_addr(op1_addr), .op2_addr(op2_addr), .imm(imm),
        .two_word(two_word), .fetch_busy(fetch_busy), .ins_valid(ins_valid),
        .fetch_err(fetch_err), .pc(pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] rom [256];
    // Architectural model: what the instruction stream says IR/imm/PC should be.
    logic [DW-1:0] m_ir, m_imm;
    logic          m_pend;
    logic [AW-1:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_ir = '0; m_imm = '0; m_pend = 1'b0; m_pc = '0;
    endtask

    task automatic model_word(input logic [DW-1:0] w);
        if (m_pend) begin
            m_imm  = w;
            m_pend = 1'b0;
        end else begin
            m_ir   = w;
            m_pend = (w[15:12] == 4'hC) || (w[15:12] == 4'hD);
        end
    endtask

    task automatic chk_fields(input string tag);
        chk({tag, ".opcode"}, 32'(opcode),   32'(m_ir[15:12]));
        chk({tag, ".op1"},    32'(op1_addr), 32'(m_ir[11:9]));
        chk({tag, ".op2"},    32'(op2_addr), 32'(m_ir[8:6]));
        chk({tag, ".two"},    32'(two_word), 32'((m_ir[15:12] == 4'hC) || (m_ir[15:12] == 4'hD)));
        chk({tag, ".imm"},    32'(imm),      32'(m_imm));
        chk({tag, ".pc"},     32'(pc),       32'(m_pc));
    endtask

    // Full fetch from IDLE with a given number of ack-less request cycles.
    task automatic fetch(input int waits, input string tag);
        logic [AW-1:0] a;
        a = m_pc;
        cs_pc_load = 1'b1; cs_ins_load = 1'b1;
        step;
        cs_pc_load = 1'b0; cs_ins_load = 1'b0;
        chk({tag, ".req"},  32'(rom_req),    32'd1);
        chk({tag, ".addr"}, 32'(rom_addr),   32'(a));
        chk({tag, ".busy"}, 32'(fetch_busy), 32'd1);
        for (int w = 0; w < waits; w++) begin
            step;
            chk({tag, ".req_wait"}, 32'(rom_req), 32'd1);
        end
        rom_ack = 1'b1; rom_rdata = rom[a];
        step;
        rom_ack = 1'b0; rom_rdata = DW'($urandom);
        model_word(rom[a]);
        chk({tag, ".valid"},    32'(ins_valid), 32'd1);
        chk({tag, ".req_drop"}, 32'(rom_req),   32'd0);
        chk_fields(tag);
        step;
        chk({tag, ".valid_pulse"}, 32'(ins_valid), 32'd0);
    endtask

    task automatic jump(input logic [AW-1:0] d, input logic inc);
        pc_wr_en = 1'b1; pc_wr_data = d; cs_pc_inc = inc;
        step;
        pc_wr_en = 1'b0; cs_pc_inc = 1'b0;
        m_pc = d; m_pend = 1'b0;
    endtask

    task automatic inc_pc;
        cs_pc_inc = 1'b1;
        step;
        cs_pc_inc = 1'b0;
        m_pc = m_pc + 1'b1;
    endtask

    initial begin
        logic [AW-1:0] a;
        int n_req, n_err, n_iv;

        for (int i = 0; i < 256; i++) begin
            rom[i] = DW'($urandom);
            if ($urandom_range(0, 3) == 0) rom[i][15:12] = 4'hC | 4'($urandom_range(0, 1));
        end
        rom[0] = 16'h0A40; rom[3] = 16'hC600; rom[4] = 16'h1234;

        // reset
        rst = 1'b1; step; step; rst = 1'b0;
        model_reset();
        chk("rst.req",   32'(rom_req),    32'd0);
        chk("rst.addr",  32'(rom_addr),   32'd0);
        chk("rst.valid", 32'(ins_valid),  32'd0);
        chk("rst.err",   32'(fetch_err),  32'd0);
        chk("rst.busy",  32'(fetch_busy), 32'd0);
        chk_fields("rst");

        // ADD at pc 0, zero wait; explicit field values
        fetch(0, "add");
        chk("add.op1_k", 32'(op1_addr), 32'd5);
        chk("add.op2_k", 32'(op2_addr), 32'd1);

        // MVI pair at 3/4 with two waits each
        jump(8'd3, 1'b0);
        fetch(2, "mvi1");
        chk("mvi1.two_k", 32'(two_word), 32'd1);
        inc_pc();
        fetch(2, "mvi2");
        chk("mvi2.imm_k", 32'(imm), 32'h1234);
        chk("mvi2.op_k",  32'(opcode), 32'hC);
        inc_pc();
        chk("mvi.pc5", 32'(pc), 32'd5);

        // timeout with a late ack that must be ignored
        cs_pc_load = 1'b1; cs_ins_load = 1'b1;
        step;
        cs_pc_load = 1'b0; cs_ins_load = 1'b0;
        n_req = 0; n_err = 0; n_iv = 0;
        for (int i = 1; i <= 21; i++) begin
            if (i > 1) begin
                if (i == 18) begin rom_ack = 1'b1; rom_rdata = 16'hFFFF; end
                step;
                rom_ack = 1'b0;
            end
            if (rom_req)   n_req++;
            if (fetch_err) n_err++;
            if (ins_valid) n_iv++;
            if (i == 16) chk("tmo.err_at16", 32'(fetch_err), 32'd1);
        end
        chk("tmo.req_cycles", 32'(n_req), 32'd15);
        chk("tmo.err_pulses", 32'(n_err), 32'd1);
        chk("tmo.no_valid",   32'(n_iv),  32'd0);
        chk_fields("tmo");

        // PC wrap and jump-over-increment priority
        jump(8'hFF, 1'b0);
        inc_pc();
        chk("wrap.pc", 32'(pc), 32'd0);
        jump(8'h40, 1'b1);
        chk("prio.pc", 32'(pc), 32'h40);

        // reset in the second wait cycle of a fetch; late ack ignored
        cs_pc_load = 1'b1; cs_ins_load = 1'b1;
        step;
        cs_pc_load = 1'b0; cs_ins_load = 1'b0;
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        model_reset();
        chk("midrst.req",  32'(rom_req),    32'd0);
        chk("midrst.busy", 32'(fetch_busy), 32'd0);
        chk_fields("midrst");
        rom_ack = 1'b1; rom_rdata = 16'hD123;
        step;
        rom_ack = 1'b0;
        chk("midrst.late_valid", 32'(ins_valid), 32'd0);
        chk_fields("midrst_late");

        // strobes during FETCH, PC moving under an outstanding fetch, load-only strobe
        jump(8'h20, 1'b0);
        a = m_pc;
        cs_pc_load = 1'b1; cs_ins_load = 1'b1;
        step;
        cs_pc_load = 1'b0; cs_ins_load = 1'b0; cs_pc_inc = 1'b1;
        step;
        cs_pc_inc = 1'b0; m_pc = m_pc + 1'b1;
        chk("busy.addr_stable", 32'(rom_addr), 32'(a));
        chk("busy.pc",          32'(pc),       32'(m_pc));
        cs_pc_load = 1'b1; cs_ins_load = 1'b1;
        step;
        chk("busy.strobe_addr", 32'(rom_addr), 32'(a));
        chk("busy.strobe_req",  32'(rom_req),  32'd1);
        rom_ack = 1'b1; rom_rdata = rom[a];
        step;
        rom_ack = 1'b0; cs_pc_load = 1'b0; cs_ins_load = 1'b0;
        model_word(rom[a]);
        chk("busy.ack_valid", 32'(ins_valid), 32'd1);
        chk("busy.ack_req",   32'(rom_req),   32'd0);
        chk_fields("busy");
        step;
        chk("busy.not_queued", 32'(rom_req), 32'd0);
        cs_pc_load = 1'b1;
        step;
        cs_pc_load = 1'b0;
        chk("loadonly.req",  32'(rom_req),  32'd0);
        chk("loadonly.addr", 32'(rom_addr), 32'(a));
        step;
        chk("loadonly.busy", 32'(fetch_busy), 32'd0);

        // randomized mix of fetches, jumps, increments and stray acks
        for (int it = 0; it < 60; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 5) begin
                fetch(int'($urandom_range(0, 4)), "rnd.fetch");
            end else if (r == 6) begin
                inc_pc();
                chk("rnd.inc", 32'(pc), 32'(m_pc));
            end else if (r == 7) begin
                jump(AW'($urandom), 1'($urandom));
                chk("rnd.jump", 32'(pc), 32'(m_pc));
            end else if (r == 8) begin
                rom_ack = 1'b1; rom_rdata = DW'($urandom);
                step;
                rom_ack = 1'b0;
                chk("rnd.stray_valid", 32'(ins_valid), 32'd0);
                chk_fields("rnd.stray");
            end else begin
                cs_pc_load = 1'b1;
                step;
                cs_pc_load = 1'b0;
                chk("rnd.loadonly", 32'(rom_req), 32'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
